// File: rtl/rf_pkg.sv
//------------------------------------------------------------------------------
// rf_pkg: shared FSM state type and default sizing for param_register_file.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package rf_pkg;

    localparam int RF_DEFAULT_WIDTH = 64;
    localparam int RF_DEFAULT_DEPTH = 32;

    typedef enum logic [0:0] {
        ST_CLEARING = 1'b0,
        ST_READY    = 1'b1
    } rf_state_t;

endpackage

`default_nettype wire

// File: rtl/rf_clear_ctrl.sv
//------------------------------------------------------------------------------
// rf_clear_ctrl: CLEARING/READY sequencer and clear-index counter.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rf_clear_ctrl
    import rf_pkg::*;
#(
    parameter int DEPTH = RF_DEFAULT_DEPTH
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     Clear,
    output logic                     ready,
    output logic                     clr_en,
    output logic [$clog2(DEPTH)-1:0] clr_idx
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    rf_state_t     state;
    rf_state_t     state_next;
    logic [AW-1:0] idx_next;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state   <= ST_CLEARING;
            clr_idx <= '0;
        end else begin
            state   <= state_next;
            clr_idx <= idx_next;
        end
    end

    // Clear requests arriving while already clearing are ignored on purpose.
    always_comb begin
        state_next = state;
        idx_next   = clr_idx;
        case (state)
            ST_CLEARING: begin
                if (clr_idx == LAST_IDX) begin
                    state_next = ST_READY;
                    idx_next   = '0;
                end else begin
                    idx_next = clr_idx + AW'(1);
                end
            end
            ST_READY: begin
                if (Clear) begin
                    state_next = ST_CLEARING;
                    idx_next   = '0;
                end
            end
            default: begin
                state_next = ST_CLEARING;
                idx_next   = '0;
            end
        endcase
    end

    assign ready  = (state == ST_READY);
    assign clr_en = (state == ST_CLEARING);

endmodule

`default_nettype wire

// File: rtl/param_register_file.sv
//------------------------------------------------------------------------------
// param_register_file: 2-read/1-write register file with hardwired zero
// register and self-clearing sequence. Option: REGFILE_BYPASS_EN.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module param_register_file
    import rf_pkg::*;
#(
    parameter int WIDTH    = RF_DEFAULT_WIDTH,
    parameter int DEPTH    = RF_DEFAULT_DEPTH,
    parameter int ZERO_REG = DEPTH - 1
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic [$clog2(DEPTH)-1:0] RA,
    input  logic [$clog2(DEPTH)-1:0] RB,
    input  logic [$clog2(DEPTH)-1:0] RW,
    input  logic [WIDTH-1:0]         BusW,
    input  logic                     RegWr,
    input  logic                     Clear,
    output logic [WIDTH-1:0]         BusA,
    output logic [WIDTH-1:0]         BusB,
    output logic                     Ready,
    output logic                     WrDropped
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] ZERO_ADDR = AW'(ZERO_REG);

    logic [WIDTH-1:0] regs [DEPTH];
    logic             ready;
    logic             clr_en;
    logic [AW-1:0]    clr_idx;
    logic             write_en;

    rf_clear_ctrl #(
        .DEPTH (DEPTH)
    ) u_clear_ctrl (
        .Clk     (Clk),
        .Reset   (Reset),
        .Clear   (Clear),
        .ready   (ready),
        .clr_en  (clr_en),
        .clr_idx (clr_idx)
    );

    assign Ready    = ready;
    // A write coinciding with a sampled Clear is discarded, not committed.
    assign write_en = ready && RegWr && !Clear && (RW != ZERO_ADDR);

    always_ff @(posedge Clk) begin
        if (clr_en) begin
            regs[clr_idx] <= '0;
        end else if (write_en) begin
            regs[RW] <= BusW;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            WrDropped <= 1'b0;
        end else begin
            WrDropped <= RegWr && (!ready || Clear);
        end
    end

    always_comb begin
        BusA = regs[RA];
`ifdef REGFILE_BYPASS_EN
        if (write_en && (RA == RW)) begin
            BusA = BusW;
        end
`endif
        if (!ready || (RA == ZERO_ADDR)) begin
            BusA = '0;
        end
    end

    always_comb begin
        BusB = regs[RB];
`ifdef REGFILE_BYPASS_EN
        if (write_en && (RB == RW)) begin
            BusB = BusW;
        end
`endif
        if (!ready || (RB == ZERO_ADDR)) begin
            BusB = '0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_param_register_file.sv
//------------------------------------------------------------------------------
// tb_param_register_file: directed table, corner sequences and random traffic
// against a behavioural model of the register file.
//------------------------------------------------------------------------------
`default_nettype none

module tb_param_register_file;

    localparam int DEPTH = 32;
    localparam int ZR    = DEPTH - 1;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [4:0]  ra, rb, rw;
    logic [63:0] busw;
    logic        regwr, clear;
    logic [63:0] busa, busb;
    logic        ready, wr_dropped;

    logic [2:0]  s_ra, s_rb, s_rw;
    logic [31:0] s_busw;
    logic        s_regwr, s_clear;
    logic [31:0] s_busa, s_busb;
    logic        s_ready, s_drop;

    always #5 Clk = ~Clk;

    param_register_file dut (
        .Clk(Clk), .Reset(Reset), .RA(ra), .RB(rb), .RW(rw), .BusW(busw),
        .RegWr(regwr), .Clear(clear), .BusA(busa), .BusB(busb),
        .Ready(ready), .WrDropped(wr_dropped)
    );

    param_register_file #(.WIDTH(32), .DEPTH(8)) dut_s (
        .Clk(Clk), .Reset(Reset), .RA(s_ra), .RB(s_rb), .RW(s_rw), .BusW(s_busw),
        .RegWr(s_regwr), .Clear(s_clear), .BusA(s_busa), .BusB(s_busb),
        .Ready(s_ready), .WrDropped(s_drop)
    );

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model: clearing is just a countdown; storage is zeroed at once
    // since it is invisible until Ready rises.
    logic [63:0] mem_m [DEPTH];
    logic        ready_m;
    logic        drop_m;
    int          rem_m;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
        ready_m = 1'b0;
        drop_m  = 1'b0;
        rem_m   = DEPTH;
    endtask

    function automatic logic [63:0] exp_rd(input logic [4:0] a);
        if (!ready_m || a == 5'(ZR)) return '0;
`ifdef REGFILE_BYPASS_EN
        if (regwr && !clear && rw != 5'(ZR) && a == rw) return busw;
`endif
        return mem_m[a];
    endfunction

    task automatic model_update();
        logic drop_n;
        drop_n = regwr && (!ready_m || clear);
        if (ready_m) begin
            if (clear) begin
                ready_m = 1'b0;
                rem_m   = DEPTH;
                for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
            end else if (regwr && rw != 5'(ZR)) begin
                mem_m[rw] = busw;
            end
        end else begin
            rem_m--;
            if (rem_m == 0) ready_m = 1'b1;
        end
        drop_m = drop_n;
    endtask

    // Called at posedge+1 with inputs already set; returns at next posedge+1.
    task automatic step();
        #1;
        chk("BusA", busa, exp_rd(ra));
        chk("BusB", busb, exp_rd(rb));
        chk("Ready", 64'(ready), 64'(ready_m));
        chk("WrDropped", 64'(wr_dropped), 64'(drop_m));
        @(posedge Clk);
        model_update();
        #1;
    endtask

    typedef struct {
        logic [4:0]  ra, rb, rw;
        logic [63:0] busw;
        logic        regwr, clear;
        logic [63:0] ea, eb;
        logic        er, ed;
    } vec_t;

    vec_t tbl [9];

    initial begin
        int cnt;
        logic [63:0] bp;
`ifdef REGFILE_BYPASS_EN
        bp = 64'h1234;
`else
        bp = 64'h0;
`endif
        tbl[0] = '{5'd5,  5'd5,  5'd5,  64'hDEADBEEF, 1, 0, 64'h0,        64'h0,        1, 0};
        tbl[1] = '{5'd5,  5'd5,  5'd0,  64'h0,        0, 0, 64'hDEADBEEF, 64'hDEADBEEF, 1, 0};
        tbl[2] = '{5'd31, 5'd5,  5'd31, 64'h55,       1, 0, 64'h0,        64'hDEADBEEF, 1, 0};
        tbl[3] = '{5'd31, 5'd31, 5'd0,  64'h0,        0, 0, 64'h0,        64'h0,        1, 0};
        tbl[4] = '{5'd7,  5'd5,  5'd7,  64'h1234,     1, 0, bp,           64'hDEADBEEF, 1, 0};
        tbl[5] = '{5'd7,  5'd7,  5'd0,  64'h0,        0, 0, 64'h1234,     64'h1234,     1, 0};
        tbl[6] = '{5'd5,  5'd3,  5'd3,  64'hAA,       1, 1, 64'hDEADBEEF, 64'h0,        1, 0};
        tbl[7] = '{5'd5,  5'd3,  5'd0,  64'h0,        0, 0, 64'h0,        64'h0,        0, 1};
        tbl[8] = '{5'd5,  5'd3,  5'd0,  64'h0,        0, 0, 64'h0,        64'h0,        0, 0};

        {ra, rb, rw, busw, regwr, clear} = '0;
        {s_ra, s_rb, s_rw, s_busw, s_regwr, s_clear} = '0;
        Reset = 1'b1;
        model_reset();
        repeat (2) @(posedge Clk);
        #1;
        chk("rst_Ready", 64'(ready), 64'h0);
        chk("rst_BusA", busa, 64'h0);
        chk("rst_WrDropped", 64'(wr_dropped), 64'h0);
        chk("rst_s_Ready", 64'(s_ready), 64'h0);
        Reset = 1'b0;

        // Post-reset clearing: 32 cycles for the big file, 8 for the small one.
        for (int i = 0; i < DEPTH + 2; i++) begin
            ra = 5'(i);
            chk("clr_s_Ready", 64'(s_ready), 64'(i >= 8));
            chk("clr_Ready", 64'(ready), 64'(i >= DEPTH));
            step();
        end
        for (int a = 0; a < DEPTH; a++) begin
            ra = 5'(a);
            rb = 5'(DEPTH - 1 - a);
            chk("zero_after_clear", busa, 64'h0);
            step();
        end

        foreach (tbl[i]) begin
            {ra, rb, rw, busw, regwr, clear} =
                {tbl[i].ra, tbl[i].rb, tbl[i].rw, tbl[i].busw, tbl[i].regwr, tbl[i].clear};
            #1;
            chk($sformatf("tbl%0d_BusA", i), busa, tbl[i].ea);
            chk($sformatf("tbl%0d_BusB", i), busb, tbl[i].eb);
            chk($sformatf("tbl%0d_Ready", i), 64'(ready), 64'(tbl[i].er));
            chk($sformatf("tbl%0d_WrDropped", i), 64'(wr_dropped), 64'(tbl[i].ed));
            step();
        end
        for (int j = 0; j < DEPTH - 2; j++) begin
            chk("clearing_Ready_low", 64'(ready), 64'h0);
            step();
        end
        ra = 5'd3; rb = 5'd5;
        #1;
        chk("clear_done_Ready", 64'(ready), 64'h1);
        chk("reg3_after_clear", busa, 64'h0);
        chk("reg5_after_clear", busb, 64'h0);
        step();

        // Reset part-way through clearing restarts from index 0.
        clear = 1'b1;
        step();
        clear = 1'b0;
        repeat (10) step();
        Reset = 1'b1;
        #2;
        model_reset();
        chk("midclr_rst_Ready", 64'(ready), 64'h0);
        Reset = 1'b0;
        cnt = 0;
        for (int k = 0; k < DEPTH + 8; k++) begin
            if (ready) break;
            cnt++;
            step();
        end
        chk("ready_latency", 64'(cnt), 64'(DEPTH));

        // Small instance: write 0..7, zero register 7 must stay 0.
        for (int i = 0; i < 8; i++) begin
            s_rw = 3'(i); s_busw = 32'hA500_0000 + 32'(i); s_regwr = 1'b1;
            step();
        end
        s_regwr = 1'b0;
        for (int i = 0; i < 8; i++) begin
            s_ra = 3'(i); s_rb = 3'(7 - i);
            #1;
            chk("s_BusA", 64'(s_busa), (i == 7) ? 64'h0 : 64'(32'hA500_0000 + 32'(i)));
            chk("s_BusB", 64'(s_busb), (i == 0) ? 64'h0 : 64'(32'hA500_0000 + 32'(7 - i)));
            chk("s_WrDropped", 64'(s_drop), 64'h0);
            step();
        end

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            ra    = 5'($urandom);
            rb    = ($urandom_range(0, 7) == 0) ? ra : 5'($urandom);
            rw    = ($urandom_range(0, 3) == 0) ? ra : 5'($urandom);
            busw  = {$urandom, $urandom};
            regwr = 1'($urandom);
            clear = ($urandom_range(0, 149) == 0);
            step();
        end
        {regwr, clear} = '0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
